// File: rtl/giu_cxs_loopback_engine_p.sv
// CXS loopback test engine: sends a programmable pattern on the CXS TX path, checks the
// looped-back RX stream lane by lane and reports match, first-mismatch and timing status.
module giu_cxs_loopback_engine_p #(
  parameter int DATA_W  = 512,
  parameter int BEATS_W = 8,
  parameter int CYC_W   = 17,
  parameter int TIMEOUT = 1024,
  localparam int NUM_LANES  = DATA_W / 32,
  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                  clk_clk,
  input  logic                  clk_reset_n,
  input  logic                  cfg_lb_en,
  input  logic                  cfg_repeat,
  input  logic [7:0]            cfg_num_tests,
  input  logic [BEATS_W-1:0]    cfg_num_beats,
  input  logic [7:0]            cfg_gap,
  input  logic                  cfg_pattern_mode,
  input  logic [31:0]           cfg_start_value,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [DATA_W-1:0]     rx_data,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_match,
  output logic                  sts_timeout,
  output logic [LANE_IDX_W-1:0] sts_mismatch_lane,
  output logic [NUM_LANES-1:0]  sts_mismatch_mask,
  output logic [31:0]           sts_mismatch_value,
  output logic [7:0]            sts_pass_count,
  output logic [CYC_W-1:0]      sts_cycle_count
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  function automatic logic [DATA_W-1:0] gen_beat(input logic [31:0] seed, input logic mode,
                                                 input logic [BEATS_W-1:0] beat);
    logic [DATA_W-1:0] v;
    logic [31:0]       base;
    logic [4:0]        rot;
    v    = '0;
    base = seed + 32'(beat) * 32'(NUM_LANES);
    for (int i = 0; i < NUM_LANES; i++) begin
      rot = 5'(32'(beat) + 32'(i));
      v[i*32 +: 32] = mode ? ((seed << rot) | (seed >> (6'd32 - 6'(rot)))) : base + 32'(i);
    end
    return v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  r_lb_en_d, r_done, r_match, r_timeout;
  logic [LANE_IDX_W-1:0] r_mm_lane;
  logic [NUM_LANES-1:0]  r_mm_mask;
  logic [31:0]           r_mm_val, r_pass_idx;
  logic [7:0]            r_pass_count, r_gap_cnt;
  logic [CYC_W-1:0]      r_cyc_count, r_cyc;
  logic [BEATS_W-1:0]    r_tx_cnt, r_rx_cnt;
  logic                  r_tx_done, r_rx_done, r_pass_end, r_tx_started;
  logic [TO_W-1:0]       r_idle;

  logic                  w_rise, w_tx_acc, w_rx_acc, w_rx_last, w_idle_exp, w_stop;
  logic                  w_run_start, w_pass_next, w_to_gap, w_done, w_timeout_hit, w_pass_init;
  logic [31:0]           w_seed, w_low_val;
  logic [DATA_W-1:0]     w_exp_rx;
  logic [NUM_LANES-1:0]  w_mask;
  logic [LANE_IDX_W-1:0] w_low_lane;
  logic [CYC_W-1:0]      w_cyc_now;

  assign w_seed     = cfg_start_value + r_pass_idx;
  assign tx_valid   = (r_state == S_RUN) & ~r_tx_done;
  assign tx_data    = tx_valid ? gen_beat(w_seed, cfg_pattern_mode, r_tx_cnt) : '0;
  assign rx_ready   = (r_state == S_RUN) & ~r_rx_done;
  assign w_rise     = cfg_lb_en & ~r_lb_en_d;
  assign w_tx_acc   = tx_valid & tx_ready;
  assign w_rx_acc   = rx_valid & rx_ready;
  assign w_rx_last  = w_rx_acc & (r_rx_cnt == cfg_num_beats);
  assign w_exp_rx   = gen_beat(w_seed, cfg_pattern_mode, r_rx_cnt);
  assign w_idle_exp = (r_state == S_RUN) & r_tx_started & ~w_rx_acc & ~r_pass_end
                    & (r_idle == TO_W'(TIMEOUT - 1));
  assign w_stop     = ~cfg_repeat | ~r_match
                    | ((cfg_num_tests != 8'd0) & (r_pass_count == cfg_num_tests));
  // A single-beat pass whose RX lands in the TX-accept cycle counts as one cycle.
  assign w_cyc_now  = r_tx_started ? sat_inc_cyc(r_cyc) : CYC_W'(1);
  assign w_pass_init = w_run_start | w_pass_next;

  always_comb begin
    w_mask     = '0;
    w_low_lane = '0;
    w_low_val  = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_mask[i] = (rx_data[i*32 +: 32] != w_exp_rx[i*32 +: 32]);
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_mask[i]) begin
        w_low_lane = LANE_IDX_W'(i);
        w_low_val  = rx_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run_start   = 1'b0;
    w_pass_next   = 1'b0;
    w_to_gap      = 1'b0;
    w_done        = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: if (w_rise) begin
        w_state_nxt = S_RUN;
        w_run_start = 1'b1;
      end
      S_RUN: begin
        if (!cfg_lb_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_pass_end) begin
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else if (cfg_gap == 8'd0) begin
            w_pass_next = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
            w_to_gap    = 1'b1;
          end
        end else if (w_idle_exp) begin
          w_state_nxt   = S_IDLE;
          w_done        = 1'b1;
          w_timeout_hit = 1'b1;
        end
      end
      S_GAP: begin
        if (!cfg_lb_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt == cfg_gap - 8'd1) begin
          w_state_nxt = S_RUN;
          w_pass_next = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      r_state      <= S_IDLE;
      r_lb_en_d    <= 1'b0;
      r_done       <= 1'b0;
      r_match      <= 1'b1;
      r_timeout    <= 1'b0;
      r_mm_lane    <= '0;
      r_mm_mask    <= '0;
      r_mm_val     <= '0;
      r_pass_idx   <= '0;
      r_pass_count <= '0;
      r_gap_cnt    <= '0;
      r_cyc_count  <= '0;
      r_cyc        <= '0;
      r_tx_cnt     <= '0;
      r_rx_cnt     <= '0;
      r_tx_done    <= 1'b0;
      r_rx_done    <= 1'b0;
      r_pass_end   <= 1'b0;
      r_tx_started <= 1'b0;
      r_idle       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lb_en_d <= cfg_lb_en;
      r_done    <= w_done;
      if (w_pass_init) begin
        r_tx_cnt     <= '0;
        r_rx_cnt     <= '0;
        r_tx_done    <= 1'b0;
        r_rx_done    <= 1'b0;
        r_pass_end   <= 1'b0;
        r_tx_started <= 1'b0;
        r_idle       <= '0;
        r_cyc        <= '0;
      end else if (r_state == S_RUN) begin
        if (w_tx_acc) begin
          if (r_tx_cnt == cfg_num_beats) r_tx_done <= 1'b1;
          else                           r_tx_cnt  <= r_tx_cnt + BEATS_W'(1);
        end
        if (r_tx_started) begin
          r_cyc <= sat_inc_cyc(r_cyc);
        end else if (w_tx_acc) begin
          r_tx_started <= 1'b1;
          r_cyc        <= CYC_W'(1);
        end
        if (w_rx_acc) begin
          r_idle <= '0;
          if (w_rx_last) begin
            r_rx_done  <= 1'b1;
            r_pass_end <= 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + BEATS_W'(1);
          end
        end else if (r_tx_started && !r_pass_end) begin
          r_idle <= r_idle + TO_W'(1);
        end
      end
      if (w_to_gap)              r_gap_cnt <= '0;
      else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 8'd1;
      // Status: cleared on run entry, otherwise updated the cycle after the RX accept.
      if (w_run_start) begin
        r_pass_idx   <= '0;
        r_match      <= 1'b1;
        r_timeout    <= 1'b0;
        r_mm_lane    <= '0;
        r_mm_mask    <= '0;
        r_mm_val     <= '0;
        r_pass_count <= '0;
        r_cyc_count  <= '0;
      end else begin
        if (w_pass_next) r_pass_idx <= r_pass_idx + 32'd1;
        if (w_rx_acc && r_match && (|w_mask)) begin
          r_match   <= 1'b0;
          r_mm_mask <= w_mask;
          r_mm_lane <= w_low_lane;
          r_mm_val  <= w_low_val;
        end
        if (w_rx_last) begin
          r_pass_count <= sat_inc8(r_pass_count);
          r_cyc_count  <= w_cyc_now;
        end
        if (w_timeout_hit) begin
          r_timeout <= 1'b1;
          r_match   <= 1'b0;
        end
      end
    end
  end

  assign sts_busy           = (r_state != S_IDLE);
  assign sts_done           = r_done;
  assign sts_match          = r_match;
  assign sts_timeout        = r_timeout;
  assign sts_mismatch_lane  = r_mm_lane;
  assign sts_mismatch_mask  = r_mm_mask;
  assign sts_mismatch_value = r_mm_val;
  assign sts_pass_count     = r_pass_count;
  assign sts_cycle_count    = r_cyc_count;
endmodule
